// File: rtl/blit_pkg.sv
// Shared types for the blitter write path.
// Word-write bundle plus a byte-lane helper.
package blit_pkg;

    localparam int BLIT_ADDR_W = 26;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } blit_word_t;

    function automatic logic [31:0] lane_put(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  value
    );
        logic [31:0] res;
        res = word;
        res[lane*8 +: 8] = value;
        return res;
    endfunction

endpackage

// File: rtl/blit_wfifo.sv
// Synchronous FIFO of word writes.
// A pop frees its slot for a same-cycle push even when full.
module blit_wfifo
    import blit_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  blit_word_t push_data,
    input  logic       pop,
    output blit_word_t head,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    blit_word_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic push_ok;
    logic pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blit_write_combiner.sv
// Byte-to-word write combiner with a queued memory write port.
// Accumulates pixel bytes per word and drains masked words to the bus.
module blit_write_combiner
    import blit_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_SLACK   = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   p4_write,
    input  logic [BLIT_ADDR_W-1:0] p4_address,
    input  logic [7:0]             p4_wdata,
    input  logic                   flush,
    output logic                   almost_full,
    output logic                   busy,
    output logic                   overflow,
    output logic                   mem_request,
    input  logic                   mem_ready,
    output logic [BLIT_ADDR_W-1:0] mem_address,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wmask
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - AF_SLACK);

    logic        acc_valid;
    logic [23:0] acc_addr;
    logic [31:0] acc_data;
    logic [3:0]  acc_mask;

    logic        nxt_valid;
    logic [23:0] nxt_addr;
    logic [31:0] nxt_data;
    logic [3:0]  nxt_mask;

    logic        push;
    blit_word_t  push_word;
    blit_word_t  head;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic        pop;
    logic        push_ok;
    logic        hit;
    logic [1:0]  lane;
    logic [3:0]  lane_bit;

    assign lane     = p4_address[1:0];
    assign lane_bit = 4'b0001 << lane;
    // A full word is never merged into; it drains and a new word begins.
    assign hit = acc_valid && (p4_address[25:2] == acc_addr)
              && (acc_mask != 4'hF);

    always_comb begin
        push      = 1'b0;
        push_word = '{addr: acc_addr, data: acc_data, mask: acc_mask};
        nxt_valid = acc_valid;
        nxt_addr  = acc_addr;
        nxt_data  = acc_data;
        nxt_mask  = acc_mask;
        if (!p4_write) begin
            push      = acc_valid;
            nxt_valid = 1'b0;
        end else if (hit) begin
            nxt_data = lane_put(acc_data, lane, p4_wdata);
            nxt_mask = acc_mask | lane_bit;
            if (flush) begin
                push      = 1'b1;
                push_word = '{addr: acc_addr, data: nxt_data, mask: nxt_mask};
                nxt_valid = 1'b0;
            end
        end else begin
            nxt_valid = 1'b1;
            nxt_addr  = p4_address[25:2];
            nxt_data  = lane_put(32'h0, lane, p4_wdata);
            nxt_mask  = lane_bit;
            if (acc_valid) begin
                push = 1'b1;
            end else if (flush) begin
                push      = 1'b1;
                push_word = '{addr: nxt_addr, data: nxt_data, mask: nxt_mask};
                nxt_valid = 1'b0;
            end
        end
    end

    assign pop        = mem_request && mem_ready;
    assign push_ok    = push && (!full || pop);
    assign count_next = count + CW'(push_ok) - CW'(pop);

    blit_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign mem_request = !empty;
    assign mem_address = empty ? '0 : {head.addr, 2'b00};
    assign mem_wdata   = empty ? '0 : head.data;
    assign mem_wmask   = empty ? '0 : head.mask;
    assign busy        = p4_write | acc_valid | !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_valid   <= 1'b0;
            acc_addr    <= '0;
            acc_data    <= '0;
            acc_mask    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            acc_valid   <= nxt_valid;
            acc_addr    <= nxt_addr;
            acc_data    <= nxt_data;
            acc_mask    <= nxt_mask;
            almost_full <= (count_next >= AF_LEVEL);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_blit_write_combiner.sv
// Directed and randomized checks of the write combiner against
// a queue-based word model.
module tb_blit_write_combiner;
    import blit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        p4_write;
    logic [25:0] p4_address;
    logic [7:0]  p4_wdata;
    logic        flush;
    logic        almost_full;
    logic        busy;
    logic        overflow;
    logic        mem_request;
    logic        mem_ready;
    logic [25:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    int compared = 0;
    int mismatched = 0;
    int accepted = 0;

    blit_word_t  q[$];
    logic        m_acc_v = 1'b0;
    logic [23:0] m_acc_a;
    logic [7:0]  m_b [4];
    logic [3:0]  m_mask;
    logic        m_af = 1'b0;
    logic        m_ovf = 1'b0;

    always #5 clock = ~clock;

    blit_write_combiner dut (
        .clock       (clock),
        .reset       (reset),
        .p4_write    (p4_write),
        .p4_address  (p4_address),
        .p4_wdata    (p4_wdata),
        .flush       (flush),
        .almost_full (almost_full),
        .busy        (busy),
        .overflow    (overflow),
        .mem_request (mem_request),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic enq_acc();
        blit_word_t w;
        w.addr = m_acc_a;
        w.data = {m_b[3], m_b[2], m_b[1], m_b[0]};
        w.mask = m_mask;
        if (q.size() >= 16) m_ovf = 1'b1;
        else q.push_back(w);
    endtask

    task automatic model_step(input logic w, input logic [25:0] a,
                              input logic [7:0] d, input logic f);
        logic pushed;
        pushed = 1'b0;
        if (!w) begin
            if (m_acc_v) enq_acc();
            m_acc_v = 1'b0;
        end else if (m_acc_v && a[25:2] == m_acc_a && m_mask != 4'hF) begin
            m_b[a[1:0]] = d;
            m_mask[a[1:0]] = 1'b1;
            if (f) begin
                enq_acc();
                m_acc_v = 1'b0;
            end
        end else begin
            if (m_acc_v) begin
                enq_acc();
                pushed = 1'b1;
            end
            m_acc_a = a[25:2];
            for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
            m_b[a[1:0]] = d;
            m_mask = 4'b0001 << a[1:0];
            m_acc_v = 1'b1;
            if (f && !pushed) begin
                enq_acc();
                m_acc_v = 1'b0;
            end
        end
    endtask

    // Drive one cycle from a negedge, check, advance model, return at negedge.
    task automatic cycle(input logic w, input logic [25:0] a,
                         input logic [7:0] d, input logic f,
                         input logic rdy, input logic rst);
        logic [31:0] bm;
        p4_write   = w;
        p4_address = a;
        p4_wdata   = d;
        flush      = f;
        mem_ready  = rdy;
        reset      = rst;
        #1;
        chk("busy", 64'(busy), 64'(w | m_acc_v | (q.size() > 0)));
        chk("request", 64'(mem_request), 64'(q.size() > 0));
        chk("almost_full", 64'(almost_full), 64'(m_af));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (q.size() > 0) begin
            for (int i = 0; i < 4; i++)
                bm[i*8 +: 8] = {8{q[0].mask[i]}};
            chk("address", 64'(mem_address), 64'({q[0].addr, 2'b00}));
            chk("wmask", 64'(mem_wmask), 64'(q[0].mask));
            chk("wdata", 64'(mem_wdata & bm), 64'(q[0].data & bm));
        end else begin
            chk("idle_out", {mem_address, mem_wdata, mem_wmask},
                64'(0));
        end
        if (rst) begin
            q.delete();
            m_acc_v = 1'b0;
            m_ovf = 1'b0;
            m_af = 1'b0;
        end else begin
            if (q.size() > 0 && rdy) begin
                void'(q.pop_front());
                accepted++;
            end
            model_step(w, a, d, f);
            m_af = (16 - q.size()) <= 6;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 26'h0, 8'h0, 1'b0, rdy, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        while ((q.size() > 0 || m_acc_v) && budget > 0) begin
            idle(1, 1'b1);
            budget--;
        end
        chk("drain_budget", 64'(budget > 0), 64'(1));
        idle(2, 1'b1);
    endtask

    initial begin
        int base;
        logic [25:0] ra;
        logic        rw;
        reset = 1'b1;
        p4_write = 1'b0;
        p4_address = '0;
        p4_wdata = '0;
        flush = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state, then four bytes into one word.
        idle(2, 1'b1);
        base = accepted;
        cycle(1'b1, 26'h100, 8'h11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 26'h101, 8'h22, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 26'h102, 8'h33, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 26'h103, 8'h44, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t1_words", 64'(accepted - base), 64'(1));

        base = accepted;
        cycle(1'b1, 26'h205, 8'hAA, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t2_words", 64'(accepted - base), 64'(1));
        chk("t2_busy", 64'(busy), 64'(0));

        base = accepted;
        cycle(1'b1, 26'h300, 8'h01, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 26'h400, 8'h02, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 26'h301, 8'h03, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t3_words", 64'(accepted - base), 64'(3));

        // Stall the bus and overfill the queue.
        for (int i = 0; i < 64; i++)
            cycle(1'b1, 26'(32'h1000 + 4 * i), 8'(i + 1), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("t4_overflow", 64'(overflow), 64'(1));
        base = accepted;
        idle(24, 1'b1);
        chk("t4_words", 64'(accepted - base), 64'(16));
        cycle(1'b0, 26'h0, 8'h0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        base = accepted;
        cycle(1'b1, 26'h502, 8'h5A, 1'b1, 1'b1, 1'b0);
        drain();
        chk("t5_words", 64'(accepted - base), 64'(1));

        for (int i = 0; i < 5; i++)
            cycle(1'b1, 26'(32'h2000 + 4 * i), 8'(i + 8'h70), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t6_queued", 64'(mem_request), 64'(1));
        base = accepted;
        cycle(1'b0, 26'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);
        chk("t6_words", 64'(accepted - base), 64'(0));

        // Random traffic in a small window so words merge and collide.
        base = $urandom_range(0, 32'h3FFF) * 16;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 31) == 0) base = $urandom_range(0, 32'h3FFF) * 16;
            ra = 26'(base + $urandom_range(0, 11));
            rw = ($urandom_range(0, 9) < 6) && !almost_full;
            cycle(rw, ra, 8'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7, 1'b0);
        end
        drain();
        chk("final_overflow", 64'(overflow), 64'(0));
        chk("final_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
